vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
Receive-side counterpart of the 640x480 VGA timing generator. Samples HS/VS on pixel strobes and recovers pixel coordinates and an active-video flag. Checks that line and frame lengths match nominal timing and reports lock. Sits on the bench and on a board loopback path beside the display core, and lets the pong renderer be checked pixel-exact.

Parameters:
H_TOTAL, 800, pixel strobes per line
V_TOTAL, 525, lines per frame
H_START, 144, h_cnt of first active pixel after HS fall (sync 96 + back porch 48)
V_START, 34, v_cnt of first active line (VS falls at line start, HS falls mid-line; hence sync 2 + BP 33 - 1)
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
LOCK_FRAMES, 2, consecutive good frames needed to lock (1..15)

Ports:
i_clk  in  1  system clock (100 MHz)
i_rst  in  1  reset, asynchronous, active-low
i_pix_stb  in  1  pixel strobe, one i_clk cycle wide (25 MHz rate)
i_hs  in  1  horizontal sync, active-low
i_vs  in  1  vertical sync, active-low
o_x  out  10  recovered x, 0..639 while o_active, else 0
o_y  out  9  recovered y, 0..479 while o_active, else 0
o_active  out  1  recovered pixel lies in the active region
o_frame_start  out  1  one-i_clk pulse on the frame reference event
o_locked  out  1  timing locked
o_err  out  1  one-i_clk pulse on any line- or frame-length mismatch

Behaviour:
- Sampling:
  - Everything advances only on i_clk cycles with i_pix_stb=1.
  - hs_prev/vs_prev hold the previous strobe's samples; they reset to 1.
  - hs_fall = hs_prev & ~i_hs. vs_armed sets on vs_prev & ~i_vs and clears on the next hs_fall.
- h_cnt (10 b):
  - hs_fall sets it to 0; otherwise it increments and saturates at 1023.
  - On hs_fall, if h_cnt != H_TOTAL-1 and h_valid=1, this is a line error.
  - h_valid sets after the first hs_fall.
- v_cnt (10 b):
  - On hs_fall with vs_armed=1 (frame reference), it goes to 0; a frame check happens if v_valid=1: error if v_cnt != V_TOTAL-1. v_valid then sets.
  - On any other hs_fall, it increments and saturates at 1023.
- Lock FSM, states SEARCH, TRACK, LOCKED:
  - Reset enters SEARCH. The first frame reference moves SEARCH to TRACK and clears good_cnt.
  - In TRACK, each error-free frame reference increments good_cnt. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - Any line or frame error in TRACK or LOCKED returns to TRACK, clears good_cnt and clears h_valid/v_valid-dependent checks, except the frame reference itself.
  - A line error and a frame reference on the same strobe: the error wins, good_cnt=0, state TRACK.
  - o_locked=1 only in LOCKED.
- Outputs:
  - All outputs are registered and appear one i_clk after the strobe cycle. They hold between strobes; pulses last one i_clk.
  - o_active = locked-independent decode: h_cnt in [H_START, H_START+H_ACTIVE) and v_cnt in [V_START, V_START+V_ACTIVE).
  - o_x = h_cnt-H_START and o_y = v_cnt-V_START, width-truncated, when active; 0 otherwise.
  - o_frame_start pulses on every frame reference. o_err pulses on every mismatch.
- Reset values: o_x=0, o_y=0, o_active=0, o_frame_start=0, o_locked=0, o_err=0, h_cnt=0, v_cnt=0, state=SEARCH. Reset mid-frame discards all history; lock needs LOCK_FRAMES+1 frame references afterwards.
- Edge cases:
  - Sync held low indefinitely: no falls, counters saturate, no error until the next fall; that fall then flags an error.
  - Glitch producing an extra hs_fall: one line error.

Optional Feature:
- Macro VGA_SYNC_DECODER_ERR_COUNT_EN.
- When defined: adds output port o_err_count, 8 b, a saturating count of o_err pulses. It stops at 255, resets to 0 on i_rst, and does not clear on relock.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - constants H_TOTAL/V_TOTAL/H_START/V_START/H_ACTIVE/V_ACTIVE/H_SYNC/V_SYNC for 640x480@60;
  - the lock-state encoding (SEARCH=0, TRACK=1, LOCKED=2).
- One sub-module, vga_sync_edge: strobe-qualified sampling of one sync line with falling-edge pulse output. It is instantiated for HS and VS.

Test Plan:
1. Drive from the 640x480 generator, reset released at line 100 -> o_frame_start first at generator line 490 h=656 (+1 clk); o_locked rises at the 3rd frame reference.
2. After lock, generator pixel (0,0) -> o_active=1, o_x=0, o_y=0. Pixel (639,479) -> o_x=639, o_y=479. Pixel (640,0) -> o_active=0, o_x=0.
3. Locked; shorten one line to 799 strobes -> one o_err pulse, o_locked=0 next clk, relock after 2 good frames.
4. Locked; one frame with 526 lines -> o_err at that frame reference, o_locked drops, o_frame_start still pulses.
5. i_rst asserted mid-frame while locked -> all outputs 0 asynchronously; after release, behaviour matches scenario 1.
6. With VGA_SYNC_DECODER_ERR_COUNT_EN: inject 300 line errors -> o_err_count=255; reset -> 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// +--------------------------------------------------------------------------+
// | vga_timing_pkg: 640x480@60 timing constants and lock-state encoding.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package vga_timing_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_START  = 144;
  localparam int V_START  = 34;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_SYNC   = 96;
  localparam int V_SYNC   = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_sync_edge.sv
// +--------------------------------------------------------------------------+
// | vga_sync_edge: strobe-qualified sampler of one active-low sync line,     |
// | giving a one-strobe falling-edge pulse. Revision: 1.0                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic sync_in,
  output logic fall
);

  logic prev;

  // Idle level is high so a line already low at reset release reads as a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b1;
    end else if (stb) begin
      prev <= sync_in;
    end
  end

  assign fall = stb & prev & ~sync_in;

endmodule

`default_nettype wire

// File: rtl/vga_sync_decoder.sv
// +--------------------------------------------------------------------------+
// | vga_sync_decoder: recovers x/y/active from HS/VS and tracks timing lock. |
// | Optional macro VGA_SYNC_DECODER_ERR_COUNT_EN adds o_err_count.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_sync_decoder #(
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int H_START     = vga_timing_pkg::H_START,
  parameter int V_START     = vga_timing_pkg::V_START,
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_active,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_err
`ifdef VGA_SYNC_DECODER_ERR_COUNT_EN
  ,
  output logic [7:0] o_err_count
`endif
);

  import vga_timing_pkg::*;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LO   = 10'(H_START);
  localparam logic [9:0] H_HI   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LO   = 10'(V_START);
  localparam logic [9:0] V_HI   = 10'(V_START + V_ACTIVE);
  localparam logic [4:0] LOCK_N = 5'(LOCK_FRAMES);

  logic        hs_fall, vs_fall;
  logic [9:0]  h_cnt, v_cnt, h_next, v_next;
  logic        vs_armed, armed_next;
  logic        h_valid, v_valid, h_valid_next, v_valid_next;
  logic [3:0]  good_cnt, good_next;
  logic [4:0]  good_sum;
  lock_state_t state, state_next;
  logic        frame_ref, line_err, frame_err, err;
  logic        active_next;
  logic [9:0]  x_next;
  logic [8:0]  y_next;

  vga_sync_edge u_hs_edge (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .stb     (i_pix_stb),
    .sync_in (i_hs),
    .fall    (hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .stb     (i_pix_stb),
    .sync_in (i_vs),
    .fall    (vs_fall)
  );

  always_comb begin
    frame_ref = hs_fall & vs_armed;
    line_err  = hs_fall & h_valid & (h_cnt != H_LAST);
    frame_err = frame_ref & v_valid & (v_cnt != V_LAST);
    err       = line_err | frame_err;

    h_next = h_cnt;
    if (hs_fall) begin
      h_next = '0;
    end else if (i_pix_stb && !(&h_cnt)) begin
      h_next = h_cnt + 10'd1;
    end

    v_next = v_cnt;
    if (frame_ref) begin
      v_next = '0;
    end else if (hs_fall && !(&v_cnt)) begin
      v_next = v_cnt + 10'd1;
    end

    // A VS fall coinciding with an HS fall arms for the following HS fall.
    armed_next = vs_armed;
    if (vs_fall) begin
      armed_next = 1'b1;
    end else if (hs_fall) begin
      armed_next = 1'b0;
    end

    // After any error the next line is unchecked; a frame reference still
    // establishes a valid frame start.
    h_valid_next = err ? 1'b0 : (h_valid | hs_fall);
    v_valid_next = frame_ref ? 1'b1 : (err ? 1'b0 : v_valid);

    state_next = state;
    good_next  = good_cnt;
    good_sum   = {1'b0, good_cnt} + 5'd1;
    case (state)
      SEARCH: begin
        if (frame_ref) begin
          state_next = TRACK;
          good_next  = '0;
        end
      end
      TRACK: begin
        if (err) begin
          good_next = '0;
        end else if (frame_ref) begin
          good_next = good_sum[3:0];
          if (good_sum >= LOCK_N) begin
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (err) begin
          state_next = TRACK;
          good_next  = '0;
        end
      end
      default: begin
        state_next = SEARCH;
        good_next  = '0;
      end
    endcase

    active_next = (h_next >= H_LO) && (h_next < H_HI) &&
                  (v_next >= V_LO) && (v_next < V_HI);
    x_next      = h_next - H_LO;
    y_next      = v_next[8:0] - V_LO[8:0];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      vs_armed <= 1'b0;
      h_valid  <= 1'b0;
      v_valid  <= 1'b0;
    end else begin
      h_cnt    <= h_next;
      v_cnt    <= v_next;
      vs_armed <= armed_next;
      h_valid  <= h_valid_next;
      v_valid  <= v_valid_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_x           <= '0;
      o_y           <= '0;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_frame_start <= frame_ref;
      o_err         <= err;
      if (i_pix_stb) begin
        o_active <= active_next;
        o_x      <= active_next ? x_next : '0;
        o_y      <= active_next ? y_next : '0;
        o_locked <= (state_next == LOCKED);
      end
    end
  end

`ifdef VGA_SYNC_DECODER_ERR_COUNT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_err_count <= '0;
    end else if (err && (o_err_count != 8'hFF)) begin
      o_err_count <= o_err_count + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire
